// File: rtl/prover_shuffle_bind_if.sv
// Handshake and data bus of the pair-binding stage: start/abort controls,
// round challenge and input array towards the block, bound array and
// status flags back from it.
interface prover_shuffle_bind_if #(
    parameter int F_NBITS  = 61,
    parameter int nValBits = 4
);
    localparam int NV = 1 << nValBits;
    localparam int NO = 1 << (nValBits - 1);

    logic                        en;
    logic                        restart;
    logic [F_NBITS-1:0]          tau;
    logic [NV-1:0][F_NBITS-1:0]  vals_in;
    logic [NO-1:0][F_NBITS-1:0]  vals_out;
    logic                        ready;
    logic                        ready_pulse;

    modport master (
        output en, restart, tau, vals_in,
        input  vals_out, ready, ready_pulse
    );

    modport slave (
        input  en, restart, tau, vals_in,
        output vals_out, ready, ready_pulse
    );
endinterface

// File: rtl/prover_shuffle_bind.sv
// Sumcheck prover bind stage: folds adjacent pairs of the shuffled array
// with the round challenge, out[j] = v[2j] + tau*(v[2j+1]-v[2j]) mod p,
// processing 2^nParBits pairs per step through multi-cycle field multipliers.

// Serial modular multiplier (MSB-first double-and-add), F_NBITS cycles per
// product. o_ready is high whenever no product is in flight.
module prover_field_mul #(
    parameter int                 F_NBITS = 61,
    parameter logic [F_NBITS-1:0] P       = 61'h1FFF_FFFF_FFFF_FFFF
) (
    input  logic               clk,
    input  logic               rstb,
    input  logic               i_start,
    input  logic               i_restart,
    input  logic [F_NBITS-1:0] i_a,
    input  logic [F_NBITS-1:0] i_b,
    output logic               o_ready,
    output logic [F_NBITS-1:0] o_prod
);
    localparam int CW = $clog2(F_NBITS + 1);

    logic               r_busy;
    logic [CW-1:0]      r_cnt;
    logic [F_NBITS-1:0] r_acc;
    logic [F_NBITS-1:0] r_a;
    logic [F_NBITS-1:0] r_b;
    logic [F_NBITS-1:0] w_dbl;
    logic [F_NBITS-1:0] w_acc_next;

    // Operands are always < p, so one conditional subtract suffices.
    function automatic logic [F_NBITS-1:0] add_mod(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[F_NBITS-1:0];
    endfunction

    assign w_dbl      = add_mod(r_acc, r_acc);
    assign w_acc_next = r_b[F_NBITS-1] ? add_mod(w_dbl, r_a) : w_dbl;
    assign o_ready    = ~r_busy;
    assign o_prod     = r_acc;

    // Iterate over the multiplier bits; restart drops any product in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
            r_a    <= '0;
            r_b    <= '0;
        end else if (i_restart) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_acc  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= CW'(F_NBITS);
            r_acc  <= '0;
            r_a    <= i_a;
            r_b    <= i_b;
        end else if (r_busy) begin
            r_acc <= w_acc_next;
            r_b   <= {r_b[F_NBITS-2:0], 1'b0};
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1)) r_busy <= 1'b0;
        end
    end
endmodule

module prover_shuffle_bind #(
    parameter int                 nValBits = 4,
    parameter int                 nParBits = 1,
    parameter int                 F_NBITS  = 61,
    parameter logic [F_NBITS-1:0] P        = 61'h1FFF_FFFF_FFFF_FFFF
) (
    input  logic                  clk,
    input  logic                  rstb,
    prover_shuffle_bind_if.slave  bus
);
    localparam int NV     = 1 << nValBits;
    localparam int NO     = 1 << (nValBits - 1);
    localparam int NL     = 1 << nParBits;
    localparam int SBITS  = nValBits - 1 - nParBits;
    localparam int SW     = (SBITS > 0) ? SBITS : 1;
    localparam int IW     = (nValBits > 1) ? nValBits - 1 : 1;
    localparam logic [SW-1:0] LAST_S = SW'((1 << SBITS) - 1);

    typedef enum logic [2:0] {S_IDLE, S_SUB, S_MUL, S_ADD, S_DONE} state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [SW-1:0]      r_s;
    logic [F_NBITS-1:0] r_tau;
    logic [F_NBITS-1:0] r_vals [NV];
    logic [F_NBITS-1:0] r_d    [NL];
    logic [F_NBITS-1:0] r_out  [NO];
    logic               r_mul_issued;

    logic               w_accept;
    logic               w_write;
    logic               w_mul_start;
    logic               w_last;
    logic               w_all_ready;
    logic [NL-1:0]      w_mul_ready;
    logic [IW-1:0]      w_j    [NL];
    logic [F_NBITS-1:0] w_v0   [NL];
    logic [F_NBITS-1:0] w_v1   [NL];
    logic [F_NBITS-1:0] w_d    [NL];
    logic [F_NBITS-1:0] w_prod [NL];
    logic [F_NBITS-1:0] w_sum  [NL];

    function automatic logic [F_NBITS-1:0] add_mod(input logic [F_NBITS-1:0] a,
                                                   input logic [F_NBITS-1:0] b);
        logic [F_NBITS:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[F_NBITS-1:0];
    endfunction

    assign w_last      = (r_s == LAST_S);
    assign w_all_ready = &w_mul_ready;

    // One lane per pair bound in parallel; lane k handles pair s*NL + k.
    for (genvar gi = 0; gi < NL; gi++) begin : g_lane
        assign w_j[gi]  = IW'(int'(r_s) * NL + gi);
        assign w_v0[gi] = r_vals[{w_j[gi], 1'b0}];
        assign w_v1[gi] = r_vals[{w_j[gi], 1'b1}];
        // p - v0 is at most p, so v1 + (p - v0) stays below 2p.
        assign w_d[gi]  = add_mod(w_v1[gi], P - w_v0[gi]);
        assign w_sum[gi] = add_mod(w_v0[gi], w_prod[gi]);

        prover_field_mul #(.F_NBITS(F_NBITS), .P(P)) u_mul (
            .clk       (clk),
            .rstb      (rstb),
            .i_start   (w_mul_start),
            .i_restart (bus.restart),
            .i_a       (r_tau),
            .i_b       (r_d[gi]),
            .o_ready   (w_mul_ready[gi]),
            .o_prod    (w_prod[gi])
        );
    end

    for (genvar gi = 0; gi < NO; gi++) begin : g_out
        assign bus.vals_out[gi] = r_out[gi];
    end

    assign bus.ready       = (r_state == S_IDLE);
    assign bus.ready_pulse = (r_state == S_DONE);

    // State register.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state and control strobes; restart overrides everything.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_write      = 1'b0;
        w_mul_start  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.en) begin
                    w_accept     = 1'b1;
                    w_state_next = S_SUB;
                end
            end
            S_SUB: w_state_next = S_MUL;
            S_MUL: begin
                // The first MUL cycle issues the start; the ready flags are
                // only meaningful from the following cycle on.
                if (!r_mul_issued)    w_mul_start  = 1'b1;
                else if (w_all_ready) w_state_next = S_ADD;
            end
            S_ADD: begin
                w_write      = 1'b1;
                w_state_next = w_last ? S_DONE : S_SUB;
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
        if (bus.restart) begin
            w_state_next = S_IDLE;
            w_accept     = 1'b0;
            w_write      = 1'b0;
            w_mul_start  = 1'b0;
        end
    end

    // Datapath: input latches, differences, step counter and result array.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_tau        <= '0;
            r_s          <= '0;
            r_mul_issued <= 1'b0;
            for (int i = 0; i < NV; i++) r_vals[i] <= '0;
            for (int k = 0; k < NL; k++) r_d[k]    <= '0;
            for (int j = 0; j < NO; j++) r_out[j]  <= '0;
        end else begin
            r_mul_issued <= (r_state == S_MUL) && !bus.restart;
            if (w_accept) begin
                r_tau <= bus.tau;
                r_s   <= '0;
                for (int i = 0; i < NV; i++) r_vals[i] <= bus.vals_in[i];
            end
            if (r_state == S_SUB && !bus.restart) begin
                for (int k = 0; k < NL; k++) r_d[k] <= w_d[k];
            end
            if (w_write) begin
                for (int k = 0; k < NL; k++) r_out[w_j[k]] <= w_sum[k];
                if (!w_last) r_s <= r_s + SW'(1);
            end
        end
    end
endmodule

// File: tb/tb_prover_shuffle_bind.sv
// Bench for prover_shuffle_bind: directed and random bind passes checked
// against a plain modular-arithmetic model of the pair fold.
module tb_prover_shuffle_bind;
    localparam int FN = 61;
    localparam logic [FN-1:0] P = 61'h1FFF_FFFF_FFFF_FFFF;
    typedef logic [FN-1:0] fe_t;

    logic clk  = 1'b0;
    logic rstb = 1'b1;
    always #5 clk = ~clk;

    prover_shuffle_bind_if #(.F_NBITS(FN), .nValBits(4)) if0 ();
    prover_shuffle_bind_if #(.F_NBITS(FN), .nValBits(3)) if1 ();

    prover_shuffle_bind #(.nValBits(4), .nParBits(1), .F_NBITS(FN), .P(P)) dut0 (
        .clk(clk), .rstb(rstb), .bus(if0));
    prover_shuffle_bind #(.nValBits(3), .nParBits(1), .F_NBITS(FN), .P(P)) dut1 (
        .clk(clk), .rstb(rstb), .bus(if1));

    int  n_checks = 0;
    int  n_pass   = 0;
    int  pulses   = 0;
    bit  prev_pulse = 1'b0;
    bit  chk_en   = 1'b0;
    fe_t exp_out  [8];
    fe_t exp_pend [8];

    task automatic check(input string name, input fe_t act, input fe_t req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    // ---------------- reference model ----------------
    function automatic fe_t mod_mul(input fe_t a, input fe_t b);
        logic [127:0] t;
        t = 128'(a) * 128'(b);
        return fe_t'(t % 128'(P));
    endfunction

    function automatic fe_t bind1(input fe_t v0, input fe_t v1, input fe_t tau);
        logic [127:0] d;
        d = (128'(v1) + 128'(P) - 128'(v0)) % 128'(P);
        return fe_t'((128'(v0) + 128'(mod_mul(tau, fe_t'(d)))) % 128'(P));
    endfunction

    function automatic void bind_all(input fe_t v[16], input fe_t tau, output fe_t o[8]);
        for (int j = 0; j < 8; j++) o[j] = bind1(v[2*j], v[2*j+1], tau);
    endfunction

    function automatic fe_t rand_fe();
        fe_t r;
        r = fe_t'({$urandom, $urandom});
        if (r == P) r = '0;
        return r;
    endfunction

    // ---------------- per-cycle compare process ----------------
    always @(negedge clk) begin
        if (rstb && chk_en) begin
            if (if0.ready || if0.ready_pulse)
                check("ready_pulse_exclusive", fe_t'(if0.ready & if0.ready_pulse), fe_t'(0));
            if (prev_pulse) begin
                check("pulse_width", fe_t'(if0.ready_pulse), fe_t'(0));
                check("ready_after_pulse", fe_t'(if0.ready), fe_t'(1));
            end
            if (if0.ready_pulse) begin
                pulses++;
                for (int j = 0; j < 8; j++) begin
                    check($sformatf("done_vals_out[%0d]", j), if0.vals_out[j], exp_pend[j]);
                    exp_out[j] = exp_pend[j];
                end
            end else if (if0.ready) begin
                for (int j = 0; j < 8; j++)
                    check($sformatf("idle_vals_out[%0d]", j), if0.vals_out[j], exp_out[j]);
            end
        end
        prev_pulse = if0.ready_pulse;
    end

    // ---------------- stimulus helpers ----------------
    task automatic start_pass(input fe_t tau, input fe_t v[16]);
        @(posedge clk); #1;
        if0.en  = 1'b1;
        if0.tau = tau;
        for (int i = 0; i < 16; i++) if0.vals_in[i] = v[i];
        @(posedge clk); #1;
        if0.en  = 1'b0;
        // Inputs are latched at start: scramble them for the rest of the pass.
        if0.tau = rand_fe();
        for (int i = 0; i < 16; i++) if0.vals_in[i] = rand_fe();
    endtask

    task automatic run_pass(input string name, input fe_t tau, input fe_t v[16], input bit inject_en);
        int p0;
        int cyc;
        bind_all(v, tau, exp_pend);
        p0 = pulses;
        start_pass(tau, v);
        if (inject_en) begin
            repeat (20) @(posedge clk);
            #1 if0.en = 1'b1;
            @(posedge clk); #1 if0.en = 1'b0;
        end
        cyc = 0;
        while (pulses == p0 && cyc < 3000) begin
            @(posedge clk); cyc++;
        end
        repeat (4) @(posedge clk);
        #1;
        check({name, "_one_pulse"}, fe_t'(pulses - p0), fe_t'(1));
        check({name, "_ready"}, fe_t'(if0.ready), fe_t'(1));
        $display("pass %s tau=%0h done after %0d cycles", name, tau, cyc);
    endtask

    fe_t vin [16];
    fe_t cin [16];
    fe_t cexp[8];

    initial begin
        if0.en = 0; if0.restart = 0; if0.tau = '0; if0.vals_in = '0;
        if1.en = 0; if1.restart = 0; if1.tau = '0; if1.vals_in = '0;
        for (int j = 0; j < 8; j++) begin exp_out[j] = '0; exp_pend[j] = '0; end

        // Reset state.
        #2 rstb = 1'b0;
        #1;
        check("reset_ready", fe_t'(if0.ready), fe_t'(1));
        check("reset_pulse", fe_t'(if0.ready_pulse), fe_t'(0));
        check("reset_vals_out7", if0.vals_out[7], fe_t'(0));
        repeat (2) @(posedge clk);
        #2 rstb = 1'b1;
        chk_en = 1'b1;

        // 1/2: identity array, tau = 0, 1, 5.
        for (int i = 0; i < 16; i++) vin[i] = fe_t'(i);
        run_pass("tau0", fe_t'(0), vin, 1'b0);
        for (int j = 0; j < 8; j++) check($sformatf("tau0_out[%0d]", j), if0.vals_out[j], fe_t'(2*j));
        run_pass("tau1", fe_t'(1), vin, 1'b0);
        for (int j = 0; j < 8; j++) check($sformatf("tau1_out[%0d]", j), if0.vals_out[j], fe_t'(2*j+1));
        run_pass("tau5", fe_t'(5), vin, 1'b0);
        for (int j = 0; j < 8; j++) check($sformatf("tau5_out[%0d]", j), if0.vals_out[j], fe_t'(2*j+5));

        // 3: wrap-around cases.
        for (int j = 0; j < 8; j++) begin vin[2*j] = fe_t'(1); vin[2*j+1] = fe_t'(0); end
        run_pass("wrap", fe_t'(2), vin, 1'b0);
        for (int j = 0; j < 8; j++) check($sformatf("wrap_out[%0d]", j), if0.vals_out[j], P - fe_t'(1));
        for (int i = 0; i < 16; i++) vin[i] = P - fe_t'(1);
        run_pass("pmax", rand_fe(), vin, 1'b0);
        for (int j = 0; j < 8; j++) check($sformatf("pmax_out[%0d]", j), if0.vals_out[j], P - fe_t'(1));

        // 4: abort during the second MUL.
        begin
            int p0;
            int cyc;
            for (int i = 0; i < 16; i++) vin[i] = fe_t'(i);
            p0 = pulses;
            start_pass(fe_t'(1), vin);
            cyc = 0;
            while (if0.vals_out[0] != fe_t'(1) && cyc < 3000) begin
                @(posedge clk); #1; cyc++;
            end
            check("abort_step0_seen", fe_t'(cyc < 3000), fe_t'(1));
            @(posedge clk); #1;
            if0.restart = 1'b1;
            exp_out[0] = fe_t'(1);
            exp_out[1] = fe_t'(3);
            @(posedge clk); #1;
            if0.restart = 1'b0;
            check("abort_ready", fe_t'(if0.ready), fe_t'(1));
            check("abort_out0", if0.vals_out[0], fe_t'(1));
            check("abort_out1", if0.vals_out[1], fe_t'(3));
            for (int j = 2; j < 8; j++) check($sformatf("abort_kept[%0d]", j), if0.vals_out[j], P - fe_t'(1));
            repeat (300) @(posedge clk);
            #1 check("abort_no_pulse", fe_t'(pulses - p0), fe_t'(0));
            $display("abort pass: restart after %0d cycles", cyc);
        end
        run_pass("after_abort", fe_t'(0), vin, 1'b1);
        for (int j = 0; j < 8; j++) check($sformatf("after_abort_out[%0d]", j), if0.vals_out[j], fe_t'(2*j));
        repeat (3) begin
            @(posedge clk); #1 check("busy_en_ignored", fe_t'(if0.ready), fe_t'(1));
        end

        // en together with restart in IDLE must not start.
        begin
            int p0;
            p0 = pulses;
            @(posedge clk); #1 if0.en = 1'b1; if0.restart = 1'b1;
            @(posedge clk); #1 if0.en = 1'b0; if0.restart = 1'b0;
            repeat (3) begin
                check("en_restart_no_start", fe_t'(if0.ready), fe_t'(1));
                @(posedge clk); #1;
            end
            check("en_restart_no_pulse", fe_t'(pulses - p0), fe_t'(0));
            $display("en+restart in idle: no start");
        end

        // 5: chain into a half-size instance.
        run_pass("chain_src", fe_t'(1), vin, 1'b0);
        for (int i = 0; i < 8; i++) cin[i] = exp_out[i];
        for (int j = 0; j < 4; j++) cexp[j] = bind1(cin[2*j], cin[2*j+1], fe_t'(3));
        begin
            int cyc;
            @(posedge clk); #1;
            if1.en = 1'b1; if1.tau = fe_t'(3);
            for (int i = 0; i < 8; i++) if1.vals_in[i] = cin[i];
            @(posedge clk); #1 if1.en = 1'b0;
            cyc = 0;
            while (!if1.ready_pulse && cyc < 3000) begin @(negedge clk); cyc++; end
            check("chain_pulse_seen", fe_t'(if1.ready_pulse), fe_t'(1));
            @(negedge clk);
            check("chain_pulse_width", fe_t'(if1.ready_pulse), fe_t'(0));
            check("chain_ready", fe_t'(if1.ready), fe_t'(1));
            for (int j = 0; j < 4; j++) begin
                check($sformatf("chain_out[%0d]", j), if1.vals_out[j], fe_t'(4*j+7));
                check($sformatf("chain_model[%0d]", j), if1.vals_out[j], cexp[j]);
            end
            $display("chain pass tau=3 done after %0d cycles", cyc);
        end

        // 6: asynchronous reset mid-MUL.
        for (int i = 0; i < 16; i++) vin[i] = rand_fe();
        start_pass(rand_fe(), vin);
        repeat (10) @(posedge clk);
        #2 rstb = 1'b0;
        for (int j = 0; j < 8; j++) exp_out[j] = '0;
        #1;
        check("midreset_ready", fe_t'(if0.ready), fe_t'(1));
        check("midreset_pulse", fe_t'(if0.ready_pulse), fe_t'(0));
        for (int j = 0; j < 8; j++) check($sformatf("midreset_out[%0d]", j), if0.vals_out[j], fe_t'(0));
        repeat (2) @(posedge clk);
        #2 rstb = 1'b1;
        $display("mid-pass reset applied");

        // Random passes.
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < 16; i++) vin[i] = rand_fe();
            run_pass($sformatf("rand%0d", n), rand_fe(), vin, n[0]);
        end

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
